// File: rtl/udp_rx_demux.sv
// rtl/udp_rx_demux.sv - Ethernet/IPv4/UDP receive parser with port demux and commit/rollback payload FIFO
//
// Purpose: parses a byte-wide, FCS-checked Ethernet frame (preamble/SFD
// already stripped). It filters on destination MAC (station or broadcast),
// IPv4 destination and a list of NUM_PORTS UDP destination ports. Payload
// bytes are written speculatively into a FIFO. A frame's bytes are committed
// only when the frame ends with a good FCS; otherwise they are rolled back.
// Committed packets are streamed out with a channel tag.
//
// Optional feature macro: UDP_RX_BCAST_IP_EN. When defined, IPv4 destination
// 255.255.255.255 is accepted in addition to my_ip.
//
// Ports:
//   clk, rst_n             clock; synchronous active-low reset
//   axiiv, axiid           input byte stream (dst MAC first)
//   rx_end, rx_fcs_ok      end-of-frame pulse and FCS status
//   mac, my_ip, port_list  station MAC, station IPv4, UDP port table
//   axiord                 consumer ready
//   axiov, axiod           output payload byte stream
//   axio_last, axio_chan   last-byte flag and matched port index
//   drop_count             saturating count of rejected frames that passed the MAC filter
module udp_rx_demux #(
    parameter int NUM_PORTS = 4,
    parameter int DEPTH     = 2048,
    parameter int MAX_PKTS  = 8,
    parameter int CHAN_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   axiiv,
    input  logic [7:0]             axiid,
    input  logic                   rx_end,
    input  logic                   rx_fcs_ok,
    input  logic [47:0]            mac,
    input  logic [31:0]            my_ip,
    input  logic [16*NUM_PORTS-1:0] port_list,
    input  logic                   axiord,
    output logic                   axiov,
    output logic [7:0]             axiod,
    output logic                   axio_last,
    output logic [CHAN_W-1:0]      axio_chan,
    output logic [15:0]            drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int MW = $clog2(MAX_PKTS);

`ifdef UDP_RX_BCAST_IP_EN
    localparam logic BCAST_IP = 1'b1;
`else
    localparam logic BCAST_IP = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_ETH, S_IP, S_UDP, S_PAY, S_WAIT_END, S_DROP
    } state_t;

    state_t              r_state;
    logic [4:0]          r_cnt;
    logic                r_mac_hit, r_bc_hit, r_ip_hit, r_ipb_hit;
    logic                r_mac_passed;
    logic                r_empty;
    logic [7:0]          r_hi;
    logic [15:0]         r_len;
    logic [15:0]         r_rem;
    logic [CHAN_W-1:0]   r_chan;
    logic [AW:0]         r_wr_ptr, r_wr_commit, r_rd_ptr;
    logic [15:0]         r_drop_count;

    logic [7:0]          r_mem [DEPTH];
    logic [15:0]         r_meta_len [MAX_PKTS];
    logic [CHAN_W-1:0]   r_meta_chan [MAX_PKTS];
    logic [MW:0]         r_meta_wr, r_meta_rd;

    logic                r_out_active;
    logic [15:0]         r_out_rem;
    logic [CHAN_W-1:0]   r_out_chan;
    logic                r_axiov, r_axio_last;
    logic [7:0]          r_axiod;
    logic [CHAN_W-1:0]   r_axio_chan;

    logic                w_full, w_meta_full, w_meta_empty;
    logic [7:0]          w_mac_byte, w_ip_byte;
    logic                w_mac_hit_n, w_bc_hit_n, w_ip_hit_n, w_ipb_hit_n;
    logic                w_port_hit;
    logic [CHAN_W-1:0]   w_port_idx;
    logic                w_commit, w_count, w_mem_we, w_take;

    // Wrap-bit pointers: the difference is DEPTH exactly when full.
    assign w_full       = (r_wr_ptr - r_rd_ptr) == (AW+1)'(DEPTH);
    assign w_meta_full  = (r_meta_wr - r_meta_rd) == (MW+1)'(MAX_PKTS);
    assign w_meta_empty = (r_meta_wr == r_meta_rd);

    always_comb begin
        w_mac_byte = 8'h00;
        case (r_cnt)
            5'd0: w_mac_byte = mac[47:40];
            5'd1: w_mac_byte = mac[39:32];
            5'd2: w_mac_byte = mac[31:24];
            5'd3: w_mac_byte = mac[23:16];
            5'd4: w_mac_byte = mac[15:8];
            5'd5: w_mac_byte = mac[7:0];
            default: w_mac_byte = 8'h00;
        endcase
    end

    // IP destination occupies header bytes 16..19, so the low two bits index it.
    always_comb begin
        w_ip_byte = 8'h00;
        case (r_cnt[1:0])
            2'd0: w_ip_byte = my_ip[31:24];
            2'd1: w_ip_byte = my_ip[23:16];
            2'd2: w_ip_byte = my_ip[15:8];
            2'd3: w_ip_byte = my_ip[7:0];
            default: w_ip_byte = 8'h00;
        endcase
    end

    assign w_mac_hit_n = r_mac_hit && (axiid == w_mac_byte);
    assign w_bc_hit_n  = r_bc_hit  && (axiid == 8'hFF);
    assign w_ip_hit_n  = r_ip_hit  && (axiid == w_ip_byte);
    assign w_ipb_hit_n = r_ipb_hit && (axiid == 8'hFF);

    // Scan from the top down so the lowest matching index wins.
    always_comb begin
        w_port_hit = 1'b0;
        w_port_idx = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (port_list[16*i +: 16] == {r_hi, axiid}) begin
                w_port_hit = 1'b1;
                w_port_idx = CHAN_W'(i);
            end
        end
    end

    assign w_commit = rx_end && rx_fcs_ok && (r_state == S_WAIT_END) && !r_empty;
    // Frames that failed the MAC filter, or that carry an empty UDP payload, are silently discarded.
    assign w_count  = rx_end && r_mac_passed && !r_empty && !w_commit;
    assign w_mem_we = axiiv && !rx_end && (r_state == S_PAY) && !w_full;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_mac_hit    <= 1'b1;
            r_bc_hit     <= 1'b1;
            r_ip_hit     <= 1'b1;
            r_ipb_hit    <= 1'b1;
            r_mac_passed <= 1'b0;
            r_empty      <= 1'b0;
            r_hi         <= '0;
            r_len        <= '0;
            r_rem        <= '0;
            r_chan       <= '0;
            r_wr_ptr     <= '0;
            r_wr_commit  <= '0;
            r_meta_wr    <= '0;
            r_drop_count <= '0;
        end else if (rx_end) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_mac_hit    <= 1'b1;
            r_bc_hit     <= 1'b1;
            r_ip_hit     <= 1'b1;
            r_ipb_hit    <= 1'b1;
            r_mac_passed <= 1'b0;
            r_empty      <= 1'b0;
            if (w_commit) begin
                r_wr_commit <= r_wr_ptr;
                r_meta_wr   <= r_meta_wr + 1'b1;
            end else begin
                r_wr_ptr <= r_wr_commit;
            end
            if (w_count && r_drop_count != 16'hFFFF)
                r_drop_count <= r_drop_count + 16'd1;
        end else if (axiiv) begin
            case (r_state)
                S_IDLE, S_ETH: begin
                    r_state <= S_ETH;
                    r_cnt   <= r_cnt + 5'd1;
                    if (r_cnt <= 5'd5) begin
                        r_mac_hit <= w_mac_hit_n;
                        r_bc_hit  <= w_bc_hit_n;
                    end
                    if (r_cnt == 5'd5) begin
                        if (w_mac_hit_n || w_bc_hit_n) r_mac_passed <= 1'b1;
                        else                           r_state      <= S_DROP;
                    end
                    if (r_cnt == 5'd12 && axiid != 8'h08) r_state <= S_DROP;
                    if (r_cnt == 5'd13) begin
                        if (axiid != 8'h00) begin
                            r_state <= S_DROP;
                        end else begin
                            r_state <= S_IP;
                            r_cnt   <= '0;
                        end
                    end
                end
                S_IP: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd0 && axiid != 8'h45) r_state <= S_DROP;
                    if (r_cnt == 5'd9 && axiid != 8'h11) r_state <= S_DROP;
                    if (r_cnt >= 5'd16) begin
                        r_ip_hit  <= w_ip_hit_n;
                        r_ipb_hit <= w_ipb_hit_n;
                    end
                    if (r_cnt == 5'd19) begin
                        if (w_ip_hit_n || (BCAST_IP && w_ipb_hit_n)) begin
                            r_state <= S_UDP;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= S_DROP;
                        end
                    end
                end
                S_UDP: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd2 || r_cnt == 5'd4) r_hi <= axiid;
                    if (r_cnt == 5'd3) begin
                        if (w_port_hit) r_chan  <= w_port_idx;
                        else            r_state <= S_DROP;
                    end
                    if (r_cnt == 5'd5) begin
                        r_len <= {r_hi, axiid};
                        if ({r_hi, axiid} < 16'd8) r_state <= S_DROP;
                    end
                    // Decide after the checksum so payload starts on the next byte.
                    if (r_cnt == 5'd7) begin
                        if (r_len == 16'd8) begin
                            r_state <= S_WAIT_END;
                            r_empty <= 1'b1;
                        end else if (w_meta_full) begin
                            r_state <= S_DROP;
                        end else begin
                            r_state <= S_PAY;
                            r_rem   <= r_len - 16'd8;
                        end
                    end
                end
                S_PAY: begin
                    if (w_full) begin
                        r_state <= S_DROP;
                    end else begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                        r_rem    <= r_rem - 16'd1;
                        if (r_rem == 16'd1) r_state <= S_WAIT_END;
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage arrays carry no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (rst_n && w_mem_we) r_mem[r_wr_ptr[AW-1:0]] <= axiid;
        if (rst_n && w_commit) begin
            r_meta_len[r_meta_wr[MW-1:0]]  <= r_len - 16'd8;
            r_meta_chan[r_meta_wr[MW-1:0]] <= r_chan;
        end
    end

    // Output: one cycle to load packet metadata, one to fetch the first byte.
    assign w_take = !r_axiov || axiord;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_ptr     <= '0;
            r_meta_rd    <= '0;
            r_out_active <= 1'b0;
            r_out_rem    <= '0;
            r_out_chan   <= '0;
            r_axiov      <= 1'b0;
            r_axiod      <= '0;
            r_axio_last  <= 1'b0;
            r_axio_chan  <= '0;
        end else begin
            if (!r_out_active && !w_meta_empty) begin
                r_out_active <= 1'b1;
                r_out_rem    <= r_meta_len[r_meta_rd[MW-1:0]];
                r_out_chan   <= r_meta_chan[r_meta_rd[MW-1:0]];
                r_meta_rd    <= r_meta_rd + 1'b1;
            end
            if (w_take) begin
                if (r_out_active && r_out_rem != 16'd0) begin
                    r_axiov     <= 1'b1;
                    r_axiod     <= r_mem[r_rd_ptr[AW-1:0]];
                    r_axio_last <= (r_out_rem == 16'd1);
                    r_axio_chan <= r_out_chan;
                    r_rd_ptr    <= r_rd_ptr + 1'b1;
                    r_out_rem   <= r_out_rem - 16'd1;
                    if (r_out_rem == 16'd1) r_out_active <= 1'b0;
                end else begin
                    r_axiov     <= 1'b0;
                    r_axio_last <= 1'b0;
                end
            end
        end
    end

    assign axiov      = r_axiov;
    assign axiod      = r_axiod;
    assign axio_last  = r_axio_last;
    assign axio_chan  = r_axio_chan;
    assign drop_count = r_drop_count;

endmodule

// File: tb/tb_udp_rx_demux.sv
// tb/tb_udp_rx_demux.sv - directed scoreboard bench for udp_rx_demux
module tb_udp_rx_demux;

    localparam int NP = 4;
    localparam int CW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            axiiv = 1'b0;
    logic [7:0]      axiid = 8'h00;
    logic            rx_end = 1'b0;
    logic            rx_fcs_ok = 1'b0;
    logic [47:0]     mac = 48'h02_11_22_33_44_55;
    logic [31:0]     my_ip = 32'hC0A8_0164;
    logic [16*NP-1:0] port_list = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
    logic            axiord = 1'b1;
    logic            axiov;
    logic [7:0]      axiod;
    logic            axio_last;
    logic [CW-1:0]   axio_chan;
    logic [15:0]     drop_count;

    udp_rx_demux #(.NUM_PORTS(NP), .DEPTH(16), .MAX_PKTS(8)) dut (
        .clk(clk), .rst_n(rst_n), .axiiv(axiiv), .axiid(axiid),
        .rx_end(rx_end), .rx_fcs_ok(rx_fcs_ok), .mac(mac), .my_ip(my_ip),
        .port_list(port_list), .axiord(axiord), .axiov(axiov), .axiod(axiod),
        .axio_last(axio_last), .axio_chan(axio_chan), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail = 0;
    int          exp_drop = 0;
    logic [10:0] sb[$];
    logic [7:0]  frame[$];
    logic [7:0]  pay[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic build(input logic [47:0] dmac, input logic [15:0] etype,
                         input logic [7:0] proto, input logic [31:0] dip,
                         input logic [15:0] dport, input logic [15:0] ulen,
                         input int pad_to);
        logic [15:0] tot;
        logic [7:0]  b;
        tot = ulen + 16'd20;
        frame.delete();
        pay.delete();
        for (int i = 5; i >= 0; i--) frame.push_back(dmac[8*i +: 8]);
        for (int i = 0; i < 6; i++) frame.push_back(8'h0A);
        frame.push_back(etype[15:8]); frame.push_back(etype[7:0]);
        frame.push_back(8'h45); frame.push_back(8'h00);
        frame.push_back(tot[15:8]); frame.push_back(tot[7:0]);
        for (int i = 0; i < 4; i++) frame.push_back(8'h00);
        frame.push_back(8'h40); frame.push_back(proto);
        frame.push_back(8'h00); frame.push_back(8'h00);
        frame.push_back(8'hC0); frame.push_back(8'hA8);
        frame.push_back(8'h01); frame.push_back(8'h02);
        for (int i = 3; i >= 0; i--) frame.push_back(dip[8*i +: 8]);
        frame.push_back(8'h12); frame.push_back(8'h34);
        frame.push_back(dport[15:8]); frame.push_back(dport[7:0]);
        frame.push_back(ulen[15:8]); frame.push_back(ulen[7:0]);
        frame.push_back(8'h00); frame.push_back(8'h00);
        for (int i = 0; i < int'(ulen) - 8; i++) begin
            b = 8'($urandom);
            pay.push_back(b);
            frame.push_back(b);
        end
        while (frame.size() < pad_to) frame.push_back(8'h00);
    endtask

    task automatic expect_pay(input logic [CW-1:0] ch);
        foreach (pay[i]) sb.push_back({(i == pay.size() - 1), ch, pay[i]});
    endtask

    task automatic send_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            axiiv = 1'b1;
            axiid = frame[i];
            @(posedge clk); #1;
        end
        axiiv = 1'b0;
    endtask

    task automatic send(input logic fcs);
        send_bytes(frame.size());
        @(posedge clk); #1;
        rx_end = 1'b1;
        rx_fcs_ok = fcs;
        @(posedge clk); #1;
        rx_end = 1'b0;
        rx_fcs_ok = 1'b0;
    endtask

    task automatic drain(input string tag, input logic rnd);
        int k = 0;
        while (sb.size() != 0 && k < 400) begin
            if (rnd) axiord = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            k++;
        end
        axiord = 1'b1;
        chk(tag, sb.size(), 0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Output monitor: scoreboard pops on each transfer and hold checks during stalls.
    logic        stall_v = 1'b0;
    logic [11:0] stall_held = '0;
    logic [10:0] exp_b;

    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_v) chk("hold_during_stall", {axiov, axio_last, axio_chan, axiod}, stall_held);
            if (axiov && axiord) begin
                chk("byte_was_expected", (sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    exp_b = sb.pop_front();
                    chk("out_byte", {axio_last, axio_chan, axiod}, exp_b);
                end
            end
            stall_v    <= axiov && !axiord;
            stall_held <= {axiov, axio_last, axio_chan, axiod};
        end else begin
            stall_v <= 1'b0;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_axiov", axiov, 0);
        chk("rst_axiod", axiod, 0);
        chk("rst_last", axio_last, 0);
        chk("rst_chan", axio_chan, 0);
        chk("rst_drop", drop_count, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Good frame to port_list[2], L=12, with output latency check.
        build(mac, 16'h0800, 8'h11, my_ip, 16'h1002, 16'd12, 0);
        expect_pay(2'd2);
        send(1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("latency_cycle1", axiov, 0);
        @(negedge clk);
        chk("latency_cycle2", axiov, 1);
        drain("drain_first", 1'b0);
        chk("drop_after_good", drop_count, exp_drop);

        // Bad FCS then a good frame: rollback must not leak bytes.
        build(mac, 16'h0800, 8'h11, my_ip, 16'h1002, 16'd12, 0);
        send(1'b0);
        exp_drop++;
        chk("drop_bad_fcs", drop_count, exp_drop);
        build(mac, 16'h0800, 8'h11, my_ip, 16'h1000, 16'd13, 0);
        expect_pay(2'd0);
        send(1'b1);
        drain("drain_after_rollback", 1'b0);

        // Broadcast MAC, padded to 60 bytes with L=9: single byte out.
        build(48'hFFFF_FFFF_FFFF, 16'h0800, 8'h11, my_ip, 16'h1001, 16'd9, 60);
        expect_pay(2'd1);
        send(1'b1);
        drain("drain_padded", 1'b0);
        chk("drop_after_padded", drop_count, exp_drop);

        // Filter rejects.
        build(mac, 16'h0806, 8'h11, my_ip, 16'h1002, 16'd12, 0);
        send(1'b1);
        exp_drop++;
        chk("drop_ethertype", drop_count, exp_drop);
        build(mac, 16'h0800, 8'h11, my_ip, 16'h2222, 16'd12, 0);
        send(1'b1);
        exp_drop++;
        chk("drop_port", drop_count, exp_drop);
        build(48'h02_AA_BB_CC_DD_EE, 16'h0800, 8'h11, my_ip, 16'h1002, 16'd12, 0);
        send(1'b1);
        chk("drop_foreign_mac", drop_count, exp_drop);
        build(mac, 16'h0800, 8'h06, my_ip, 16'h1002, 16'd12, 0);
        send(1'b1);
        exp_drop++;
        chk("drop_proto", drop_count, exp_drop);
        build(mac, 16'h0800, 8'h11, my_ip, 16'h1003, 16'd8, 0);
        send(1'b1);
        chk("drop_empty_udp", drop_count, exp_drop);
        build(mac, 16'h0800, 8'h11, my_ip, 16'h1003, 16'd5, 0);
        send(1'b1);
        exp_drop++;
        chk("drop_short_len", drop_count, exp_drop);
        repeat (6) @(posedge clk);
        #1;
        chk("no_output_after_rejects", axiov, 0);

        // FIFO fill with the consumer stalled: third packet overflows.
        axiord = 1'b0;
        build(mac, 16'h0800, 8'h11, my_ip, 16'h1003, 16'd16, 0);
        expect_pay(2'd3);
        send(1'b1);
        build(mac, 16'h0800, 8'h11, my_ip, 16'h1000, 16'd16, 0);
        expect_pay(2'd0);
        send(1'b1);
        build(mac, 16'h0800, 8'h11, my_ip, 16'h1001, 16'd16, 0);
        send(1'b1);
        exp_drop++;
        repeat (5) @(posedge clk);
        #1;
        chk("drop_overflow", drop_count, exp_drop);
        chk("stalled_valid", axiov, 1);
        drain("drain_overflow", 1'b1);

        // Reset in the middle of a payload, then a clean frame.
        build(mac, 16'h0800, 8'h11, my_ip, 16'h1000, 16'd16, 0);
        send_bytes(46);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_drop = 0;
        chk("drop_after_reset", drop_count, exp_drop);
        chk("axiov_after_reset", axiov, 0);
        build(mac, 16'h0800, 8'h11, my_ip, 16'h1001, 16'd11, 0);
        expect_pay(2'd1);
        send(1'b1);
        drain("drain_after_reset", 1'b0);
        chk("drop_after_reset_frame", drop_count, exp_drop);

        // Broadcast destination IP.
        build(mac, 16'h0800, 8'h11, 32'hFFFF_FFFF, 16'h1002, 16'd10, 0);
`ifdef UDP_RX_BCAST_IP_EN
        expect_pay(2'd2);
`else
        exp_drop++;
`endif
        send(1'b1);
        drain("drain_bcast_ip", 1'b0);
        chk("drop_bcast_ip", drop_count, exp_drop);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/udp_rx_demux.md
Name: udp_rx_demux

Overview:
- Parametrised successor to the fixed receive stack.
- Consumes a byte-wide, FCS-checked Ethernet frame stream (preamble/SFD already stripped).
- Parses Ethernet, IPv4 and UDP headers in one state machine and filters on MAC, IP and a programmable list of NUM_PORTS UDP ports.
- Buffers payload in a commit/rollback FIFO and emits only good packets on a ready/valid stream tagged with a channel index. Sits between the RMII byte assembler and application consumers.

Parameters:
NUM_PORTS, 4, number of UDP destination ports/channels matched (1..16)
DEPTH, 2048, payload FIFO depth in bytes (power of 2)
MAX_PKTS, 8, packet-metadata FIFO entries (power of 2)
CHAN_W, $clog2(NUM_PORTS) min 1, channel tag width

Ports:
clk  in  1  system clock (50 MHz)
rst_n  in  1  reset; synchronous, active-low
axiiv  in  1  input byte valid
axiid  in  8  input byte, frame order (dst MAC first)
rx_end  in  1  one-cycle pulse, no earlier than the cycle after the last frame byte; never coincident with axiiv
rx_fcs_ok  in  1  FCS good; sampled only with rx_end
mac  in  48  station MAC
my_ip  in  32  station IPv4 address
port_list  in  16*NUM_PORTS  entry i = bits [16i+15:16i]
axiord  in  1  consumer ready
axiov  out  1  output byte valid
axiod  out  8  payload byte
axio_last  out  1  final byte of packet
axio_chan  out  CHAN_W  index of matched port; constant across a packet
drop_count  out  16  frames rejected after passing the MAC filter; saturates at 16'hFFFF

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE; all pointers, counters and drop_count =0; axiov=0, axiod=0, axio_last=0, axio_chan=0. Any partial or buffered packet is discarded.
- States: IDLE -> ETH(14B) -> IP(20B) -> UDP(8B) -> PAY -> WAIT_END. DROP is entered from any parse state. Every state returns to IDLE on rx_end.
- ETH: dst MAC must equal mac or FF:FF:FF:FF:FF:FF, else DROP (not counted). Ethertype must be 0x0800, else DROP (counted).
- IP: byte 0 must be 0x45; protocol (byte 9) must be 0x11; dst IP (bytes 16-19) must equal my_ip. Any failure -> DROP (counted).
- UDP: dst port compared against all port_list entries. Lowest matching index is latched to the channel. No match -> DROP (counted).
- UDP length field L: if L<8 -> DROP (counted). If L==8 -> WAIT_END; the frame is discarded and not counted.
- PAY: writes L-8 bytes to the FIFO at speculative wr_ptr, then -> WAIT_END. Bytes beyond L-8 (Ethernet padding) are ignored.
- FIFO full while in PAY -> DROP (counted). Metadata FIFO full at the UDP->PAY transition -> DROP (counted).
- rx_end with rx_fcs_ok=1 in WAIT_END -> commit: wr_commit<=wr_ptr; push {length, chan} to the metadata FIFO.
- rx_end in any other state or with rx_fcs_ok=0 -> rollback: wr_ptr<=wr_commit. Counted unless the MAC filter failed or L==8.
- Counted drops increment drop_count by exactly 1 per frame.
- rx_end in PAY (truncated frame) -> rollback, counted.
- Pointers are DEPTH-wide with an extra wrap bit. full = wr_ptr - rd_ptr == DEPTH. Reads use committed data only.
- Output: axiov asserts exactly 2 cycles after the commit cycle when the output was idle.
- A byte transfers on axiov&&axiord; the next byte is presented on the following cycle (full throughput).
- axiod, axio_last and axio_chan are held stable while axiov&&!axiord.
- After axio_last transfers, the next queued packet follows with no more than 2 idle cycles.
- Commit and read in the same cycle are both honoured.

Optional Feature:
- Macro UDP_RX_BCAST_IP_EN.
- Defined: dst IP 255.255.255.255 is accepted in addition to my_ip.
- Undefined: only my_ip is accepted; broadcast IP frames are dropped and counted.

Test Plan:
- Frame to mac, my_ip, dst port = port_list[2], L=12, fcs_ok=1 -> 4 bytes out, axio_chan=2, axio_last on the 4th byte, axiov rising 2 cycles after rx_end; drop_count=0.
- Same frame with rx_fcs_ok=0 -> no output, drop_count=1. A following good frame is output with its correct payload (rollback verified).
- Frame padded to 60 bytes with L=9 -> exactly 1 payload byte out.
- Ethertype 0x0806, then wrong port, then foreign MAC -> drop_count=2; no output.
- DEPTH=16, 3 x 8-byte packets with axiord=0 -> first two are committed, third is dropped (drop_count=1). Raise axiord -> 16 bytes out; axiod is held stable throughout stalls.
- rst_n low mid-payload, then a good frame -> only the new frame is output; drop_count=0. Repeat with dst IP 255.255.255.255: output with UDP_RX_BCAST_IP_EN defined, drop without it.
